// File: rtl/err_avg_unit.sv
// err_avg_unit: moving-average datapath for the PID error term.
// A shift_avg pulse pushes err_in into a DEPTH-tap history buffer.
// A calc_avg pulse starts a sum of the taps, one tap per clock. The sum is
// then scaled by DEPTH using an arithmetic (floor) right shift. The result
// is held on avg_out while avg_done stays high.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active-high
//   shift_avg  in   pulse: push err_in into the history
//   calc_avg   in   pulse: start an average computation
//   err_in     in   signed error sample, sampled with shift_avg
//   avg_out    out  signed average, stable while avg_done=1
//   avg_done   out  level, average valid
//   busy       out  high in ACCUM and SCALE
//   hist_full  out  high once DEPTH samples have been shifted in
//   proto_err  out  sticky, a request arrived while busy
//
// state | meaning
// IDLE  | after reset, no result yet
// ACCUM | summing one tap per clock
// SCALE | shifting the sum down into avg_out
// DONE  | result held, avg_done high until the next request
module err_avg_unit #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     shift_avg,
  input  logic                     calc_avg,
  input  logic signed [DATA_W-1:0] err_in,
  output logic signed [DATA_W-1:0] avg_out,
  output logic                     avg_done,
  output logic                     busy,
  output logic                     hist_full,
  output logic                     proto_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int ACC_W = DATA_W + DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_SCALE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic signed [DATA_W-1:0] tap_q [DEPTH];
  logic signed [DATA_W-1:0] tap_d [DEPTH];
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [DEPTH_LOG2-1:0]    idx_q, idx_d;
  logic [DEPTH_LOG2:0]      cnt_q, cnt_d;
  logic signed [DATA_W-1:0] avg_q, avg_d;
  logic                     done_q, done_d;
  logic                     perr_q, perr_d;

  logic accept;
  logic shift_ok;
  logic calc_ok;
  logic busy_s;

  assign busy_s   = (state_q == S_ACCUM) || (state_q == S_SCALE);
  assign accept   = (state_q == S_IDLE) || (state_q == S_DONE);
  assign shift_ok = shift_avg && accept;
  assign calc_ok  = calc_avg && accept;

  // State register and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) tap_q[i] <= '0;
      acc_q  <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
      avg_q  <= '0;
      done_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      avg_q   <= avg_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (calc_avg) state_d = S_ACCUM;
      S_ACCUM: if (idx_q == DEPTH_LOG2'(DEPTH - 1)) state_d = S_SCALE;
      S_SCALE: state_d = S_DONE;
      S_DONE:  if (calc_avg) state_d = S_ACCUM;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    tap_d  = tap_q;
    acc_d  = acc_q;
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    avg_d  = avg_q;
    done_d = done_q;
    perr_d = perr_q;

    // A shift on the same edge as a calc lands before ACCUM reads the taps,
    // so the computation includes the new sample.
    if (shift_ok) begin
      tap_d[0] = err_in;
      for (int i = 1; i < DEPTH; i++) tap_d[i] = tap_q[i-1];
      if (cnt_q != (DEPTH_LOG2+1)'(DEPTH)) cnt_d = cnt_q + (DEPTH_LOG2+1)'(1);
    end

    // Any accepted request in DONE invalidates the held result.
    if (state_q == S_DONE && (shift_avg || calc_avg)) done_d = 1'b0;

    if (calc_ok) begin
      acc_d = '0;
      idx_d = '0;
    end

    if (state_q == S_ACCUM) begin
      acc_d = acc_q + ACC_W'(tap_q[idx_q]);
      idx_d = idx_q + DEPTH_LOG2'(1);
    end

    // The floor-divided sum of DEPTH DATA_W-bit samples always fits in DATA_W.
    if (state_q == S_SCALE) begin
      avg_d  = DATA_W'(acc_q >>> DEPTH_LOG2);
      done_d = 1'b1;
    end

    if (busy_s && (shift_avg || calc_avg)) perr_d = 1'b1;
  end

  // Output decode
  always_comb begin
    avg_out   = avg_q;
    avg_done  = done_q;
    busy      = busy_s;
    hist_full = (cnt_q == (DEPTH_LOG2+1)'(DEPTH));
    proto_err = perr_q;
  end

endmodule

// File: doc/err_avg_unit.md
Name: err_avg_unit

Overview:
- Moving-average datapath for the PID error term; the responder to the controller's averaging handshake.
- Each `shift_avg` pulse loads the current error sample into a DEPTH-tap history buffer.
- Each `calc_avg` pulse starts a sequential sum-and-scale of the history, one tap per clock.
- When the average is ready, the block drives `avg_out` and holds `avg_done` high, so the controller can leave its averaging wait state.

Parameters:
- DATA_W, 16: width of the signed error sample and of the average.
- DEPTH_LOG2, 3: log2 of the tap count; DEPTH = 2**DEPTH_LOG2 (default 8).

Ports:
- clk  in  1  system clock; rising edge.
- rst  in  1  asynchronous reset, active-high.
- shift_avg  in  1  single-cycle pulse: push `err_in` into the history.
- calc_avg  in  1  single-cycle pulse: start an average computation.
- err_in  in  DATA_W  signed error sample; sampled on the edge where `shift_avg`=1.
- avg_out  out  DATA_W  signed average; stable while `avg_done`=1.
- avg_done  out  1  level; average valid.
- busy  out  1  high in the ACCUM and SCALE states.
- hist_full  out  1  high once DEPTH samples have been shifted in since reset.
- proto_err  out  1  sticky; a request arrived while busy.

Behaviour:
- Reset (asynchronous, rst=1):
  - State goes to IDLE.
  - All taps, the accumulator, the index, the fill count, `avg_out`, `avg_done`, `busy`, `hist_full` and `proto_err` go to 0.
  - Reset asserted mid-computation aborts the computation immediately; no `avg_done` follows.
- History buffer:
  - `shift_avg` accepted in IDLE or DONE: tap[0] <= `err_in`, tap[i] <= tap[i-1], and tap[DEPTH-1] is discarded.
  - The fill count saturates at DEPTH; `hist_full` = (count == DEPTH).
  - Taps never written since reset hold 0 and contribute 0 to the sum.
- States: IDLE, ACCUM, SCALE, DONE.
  - IDLE --calc_avg--> ACCUM: acc <= 0, idx <= 0.
  - ACCUM, each edge: acc <= acc + sign-extended tap[idx], idx <= idx + 1. When idx == DEPTH-1, go to SCALE.
  - SCALE, one edge: `avg_out` <= acc >>> DEPTH_LOG2 (arithmetic shift, floor rounding, low DATA_W bits); `avg_done` <= 1; go to DONE.
  - DONE: hold `avg_out` and `avg_done`.
    - `shift_avg` clears `avg_done` and stays in DONE; the result is retained until the next calc.
    - `calc_avg` clears `avg_done` and goes to ACCUM.
  - IDLE is entered only from reset.
- Latency: `calc_avg` sampled on edge N; `avg_done` first reads 1 after edge N+DEPTH+1, i.e. DEPTH+1 edges later (9 edges at the default).
- Arithmetic:
  - Accumulator width is DATA_W+DEPTH_LOG2, signed; it cannot overflow.
  - The scaled result always fits in DATA_W; no saturation logic is needed.
- Simultaneous events and busy-time requests:
  - `shift_avg` and `calc_avg` on the same edge in IDLE/DONE: the shift is applied on that edge, and the computation uses the updated history (including the new sample).
  - `shift_avg` or `calc_avg` while `busy`=1: the request is dropped, the history and the running computation are unaffected, and `proto_err` <= 1 until reset.
- Outputs are registered or decoded directly from state; there is no combinational path from the inputs to the outputs.

Test Plan:
1. Assert rst mid-ACCUM (after 3 accumulate edges) -> on the same edge all outputs read 0, state is IDLE, and no `avg_done` follows.
2. Shift 8 samples of +100, then pulse `calc_avg` -> `busy` high for 9 edges, then `avg_out`=100 and `avg_done`=1, held until the next request. `hist_full`=1 after the 8th shift.
3. From reset, shift a single -1 and calc -> sum -1, `avg_out` = -1 (floor of -1/8). Shift a single +7 from reset and calc -> `avg_out`=0.
4. Extremes: 8 samples of -32768 -> `avg_out`=-32768; 8 samples of 32767 -> `avg_out`=32767; no wrap.
5. Shift 9 samples with values 1..9, then calc -> the sample of value 1 is discarded; sum 44, `avg_out`=5. A second calc without new shifts also gives 5.
6. Pulse `shift_avg` and `calc_avg` on the same cycle with 7 prior samples of 8 and a new sample of 16 -> `avg_out`=9. A `shift_avg` during ACCUM -> `proto_err`=1 and the result is still 9.
